// File: rtl/vai_tx_if.sv
// Simplified CCI-P Tx bundle (c0 read req, c1 write req + data, c2 mmio read response)
// shared by the input and output sides of vai_tx_auditor.
interface vai_tx_if;
    logic         c0_valid;
    logic [3:0]   c0_req_type;
    logic [41:0]  c0_address;
    logic [15:0]  c0_mdata;
    logic         c1_valid;
    logic [3:0]   c1_req_type;
    logic [41:0]  c1_address;
    logic [15:0]  c1_mdata;
    logic [511:0] c1_data;
    logic         c2_mmio_rd_valid;
    logic [8:0]   c2_tid;
    logic [63:0]  c2_data;

    modport master (
        output c0_valid, c0_req_type, c0_address, c0_mdata,
        output c1_valid, c1_req_type, c1_address, c1_mdata, c1_data,
        output c2_mmio_rd_valid, c2_tid, c2_data
    );

    modport slave (
        input c0_valid, c0_req_type, c0_address, c0_mdata,
        input c1_valid, c1_req_type, c1_address, c1_mdata, c1_data,
        input c2_mmio_rd_valid, c2_tid, c2_data
    );
endinterface

// File: rtl/vai_tx_auditor.sv
// Two-stage Tx auditor: per-vmid address translation, mdata vmid tagging and reset gating.
// Optional macro VAI_AUDIT_MDATA_CHECK_EN drops requests arriving with nonzero vmid tag bits.
module vai_tx_auditor #(
    parameter int NUM_SUB_AFUS = 8,
    localparam int VMID_WIDTH  = $clog2(NUM_SUB_AFUS)
) (
    input  logic                         Clk,
    input  logic                         Resetb,
    input  logic [VMID_WIDTH-1:0]        vmid,
    vai_tx_if.slave                      in_Tx,
    input  logic [NUM_SUB_AFUS-1:0][63:0] offset_array,
    input  logic [63:0]                  sub_afu_reset,
    vai_tx_if.master                     out_Tx,
    output logic [15:0]                  drop_cnt,
    output logic                         audit_err
);
    localparam logic [3:0] REQ_WRFENCE = 4'h4;
    localparam int         LOW_W       = 16 - VMID_WIDTH;

    logic [41:0]           sel_offset_s;
    logic                  gate_s;
    logic                  c0_tag_err_s;
    logic                  c1_tag_err_s;
    logic                  c0_drop_s;
    logic                  c1_drop_s;
    logic [16:0]           cnt_sum_s;
    logic [15:0]           drop_cnt_nxt_s;
    logic                  unused_s;
    logic [41:0]           t2_c0_addr_s;
    logic [41:0]           t2_c1_addr_s;

    logic                  t1_c0_valid_r;
    logic [3:0]            t1_c0_req_type_r;
    logic [41:0]           t1_c0_addr_r;
    logic [LOW_W-1:0]      t1_c0_mdata_r;
    logic                  t1_c1_valid_r;
    logic [3:0]            t1_c1_req_type_r;
    logic [41:0]           t1_c1_addr_r;
    logic [LOW_W-1:0]      t1_c1_mdata_r;
    logic [511:0]          t1_c1_data_r;
    logic                  t1_c2_valid_r;
    logic [8:0]            t1_c2_tid_r;
    logic [63:0]           t1_c2_data_r;
    logic [VMID_WIDTH-1:0] t1_vmid_r;
    logic [41:0]           t1_offset_r;

    // Select the owning vmid's offset and decide drops at capture time
    always_comb begin
        sel_offset_s = 42'd0;
        unused_s     = 1'b0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            if (vmid == i[VMID_WIDTH-1:0]) begin
                sel_offset_s = offset_array[i][41:0];
            end else begin
                sel_offset_s = sel_offset_s;
            end
            unused_s = unused_s ^ (^offset_array[i][63:42]);
        end
        unused_s = unused_s ^ (^in_Tx.c0_mdata[15 -: VMID_WIDTH]) ^ (^in_Tx.c1_mdata[15 -: VMID_WIDTH]);
        gate_s   = sub_afu_reset[vmid];
`ifdef VAI_AUDIT_MDATA_CHECK_EN
        c0_tag_err_s = in_Tx.c0_valid && (in_Tx.c0_mdata[15 -: VMID_WIDTH] != {VMID_WIDTH{1'b0}});
        c1_tag_err_s = in_Tx.c1_valid && (in_Tx.c1_mdata[15 -: VMID_WIDTH] != {VMID_WIDTH{1'b0}});
`else
        c0_tag_err_s = 1'b0;
        c1_tag_err_s = 1'b0;
`endif
        c0_drop_s = in_Tx.c0_valid && (gate_s || c0_tag_err_s);
        c1_drop_s = in_Tx.c1_valid && (gate_s || c1_tag_err_s);
        cnt_sum_s = {1'b0, drop_cnt} + {16'd0, c0_drop_s} + {16'd0, c1_drop_s};
        if (cnt_sum_s[16]) begin
            drop_cnt_nxt_s = 16'hFFFF;
        end else begin
            drop_cnt_nxt_s = cnt_sum_s[15:0];
        end
    end

    // T1 capture: request, vmid and its offset frozen together
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            t1_c0_valid_r    <= 1'b0;
            t1_c0_req_type_r <= 4'd0;
            t1_c0_addr_r     <= 42'd0;
            t1_c0_mdata_r    <= {LOW_W{1'b0}};
            t1_c1_valid_r    <= 1'b0;
            t1_c1_req_type_r <= 4'd0;
            t1_c1_addr_r     <= 42'd0;
            t1_c1_mdata_r    <= {LOW_W{1'b0}};
            t1_c1_data_r     <= 512'd0;
            t1_c2_valid_r    <= 1'b0;
            t1_c2_tid_r      <= 9'd0;
            t1_c2_data_r     <= 64'd0;
            t1_vmid_r        <= {VMID_WIDTH{1'b0}};
            t1_offset_r      <= 42'd0;
        end else begin
            t1_c0_valid_r    <= in_Tx.c0_valid && !c0_drop_s;
            t1_c0_req_type_r <= in_Tx.c0_req_type;
            t1_c0_addr_r     <= in_Tx.c0_address;
            t1_c0_mdata_r    <= in_Tx.c0_mdata[LOW_W-1:0];
            t1_c1_valid_r    <= in_Tx.c1_valid && !c1_drop_s;
            t1_c1_req_type_r <= in_Tx.c1_req_type;
            t1_c1_addr_r     <= in_Tx.c1_address;
            t1_c1_mdata_r    <= in_Tx.c1_mdata[LOW_W-1:0];
            t1_c1_data_r     <= in_Tx.c1_data;
            t1_c2_valid_r    <= in_Tx.c2_mmio_rd_valid;
            t1_c2_tid_r      <= in_Tx.c2_tid;
            t1_c2_data_r     <= in_Tx.c2_data;
            t1_vmid_r        <= vmid;
            t1_offset_r      <= sel_offset_s;
        end
    end

    // Address translation; fences keep their address, sums wrap at 2^42
    always_comb begin
        t2_c0_addr_s = t1_c0_addr_r + t1_offset_r;
        if (t1_c1_req_type_r == REQ_WRFENCE) begin
            t2_c1_addr_s = t1_c1_addr_r;
        end else begin
            t2_c1_addr_s = t1_c1_addr_r + t1_offset_r;
        end
    end

    // T2 stage drives the registered out_Tx bundle
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            out_Tx.c0_valid         <= 1'b0;
            out_Tx.c0_req_type      <= 4'd0;
            out_Tx.c0_address       <= 42'd0;
            out_Tx.c0_mdata         <= 16'd0;
            out_Tx.c1_valid         <= 1'b0;
            out_Tx.c1_req_type      <= 4'd0;
            out_Tx.c1_address       <= 42'd0;
            out_Tx.c1_mdata         <= 16'd0;
            out_Tx.c1_data          <= 512'd0;
            out_Tx.c2_mmio_rd_valid <= 1'b0;
            out_Tx.c2_tid           <= 9'd0;
            out_Tx.c2_data          <= 64'd0;
        end else begin
            out_Tx.c0_valid         <= t1_c0_valid_r;
            out_Tx.c0_req_type      <= t1_c0_req_type_r;
            out_Tx.c0_address       <= t2_c0_addr_s;
            out_Tx.c0_mdata         <= {t1_vmid_r, t1_c0_mdata_r};
            out_Tx.c1_valid         <= t1_c1_valid_r;
            out_Tx.c1_req_type      <= t1_c1_req_type_r;
            out_Tx.c1_address       <= t2_c1_addr_s;
            out_Tx.c1_mdata         <= {t1_vmid_r, t1_c1_mdata_r};
            out_Tx.c1_data          <= t1_c1_data_r;
            out_Tx.c2_mmio_rd_valid <= t1_c2_valid_r;
            out_Tx.c2_tid           <= t1_c2_tid_r;
            out_Tx.c2_data          <= t1_c2_data_r;
        end
    end

    // Saturating drop counter
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            drop_cnt <= 16'd0;
        end else begin
            drop_cnt <= drop_cnt_nxt_s;
        end
    end

`ifdef VAI_AUDIT_MDATA_CHECK_EN
    // Sticky tag-violation flag
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            audit_err <= 1'b0;
        end else begin
            audit_err <= audit_err || c0_tag_err_s || c1_tag_err_s;
        end
    end
`else
    assign audit_err = 1'b0;
`endif
endmodule

// File: doc/vai_tx_auditor.md
VAI_TX_AUDITOR -- requirements
Module: vai_tx_auditor

Interface
REQ-001 SHALL have parameter NUM_SUB_AFUS, default 8, giving the number of sub-AFUs; VMID_WIDTH = $clog2(NUM_SUB_AFUS).
REQ-002 SHALL have port Clk, input, 1, the single clock (pClk domain).
REQ-003 SHALL have port Resetb, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port vmid, input, VMID_WIDTH, the sub-AFU id owning in_Tx this cycle.
REQ-005 SHALL have port in_Tx, input, t_if_ccip_Tx, Tx from the selected sub-AFU.
REQ-006 SHALL have port offset_array, input, 64 x NUM_SUB_AFUS, per-vmid cache-line address offsets from vai_mgr.
REQ-007 SHALL have port sub_afu_reset, input, 64, per-vmid reset mask from vai_mgr; bit i gates vmid i.
REQ-008 SHALL have port out_Tx, output, t_if_ccip_Tx, audited Tx toward vai_mgr afu_TxPort.
REQ-009 SHALL have port drop_cnt, output, 16, count of dropped requests.
REQ-010 SHALL have port audit_err, output, 1, sticky mdata-tag violation flag.

Function
REQ-011 SHALL pipeline all three channels through exactly two register stages (T1 capture, T2 translate); latency 2 cycles for c0, c1 and c2.
REQ-012 SHALL capture in_Tx, vmid and offset_array[vmid] together at T1; a later offset_array change SHALL NOT affect an in-flight request.
REQ-013 SHALL set T2 c0/c1 hdr.address = in address + offset[41:0], modulo 2^42 (wrap, no carry out, no error).
REQ-014 SHALL NOT translate address for a c1 request with req_type eREQ_WRFENCE; fence passes unmodified except tagging.
REQ-015 SHALL overwrite hdr.mdata[15:16-VMID_WIDTH] of every forwarded c0/c1 request with the T1 vmid.
REQ-016 SHALL forward c1 data unmodified and c2 (mmio response) unmodified with the same 2-cycle latency.
REQ-017 SHALL drop a c0/c1 request (output valid 0) when sub_afu_reset[vmid] is 1 at T1; c2 is never dropped.
REQ-018 SHALL increment drop_cnt by 1 per dropped request, by 2 when c0 and c1 drop in the same cycle, saturating at 16'hFFFF.
REQ-019 SHALL not stall or backpressure; upstream obeys c0TxAlmFull/c1TxAlmFull from vai_mgr, whose threshold covers these 2 cycles.
REQ-020 SHALL hold out_Tx valid bits 0 when the matching T2 stage is empty; payload fields are don't-care when invalid.
REQ-021 SHALL handle simultaneous valid c0, c1, c2 in one cycle independently with no interaction.

Reset
REQ-022 SHALL, while Resetb is 0, drive out_Tx.c0.valid, out_Tx.c1.valid, out_Tx.c2.mmioRdValid = 0, drop_cnt = 0, audit_err = 0, and clear all T1/T2 valids.
REQ-023 SHALL discard any in-flight requests when Resetb asserts mid-operation; none SHALL emerge after release.
REQ-024 SHALL accept a new request on the first Clk edge after Resetb deasserts; its output appears 2 cycles later.

Configuration
REQ-025 SHALL honour macro VAI_AUDIT_MDATA_CHECK_EN.
REQ-026 SHALL, with VAI_AUDIT_MDATA_CHECK_EN defined, drop any c0/c1 request whose incoming mdata[15:16-VMID_WIDTH] is nonzero, set audit_err sticky, and count it in drop_cnt.
REQ-027 SHALL, without VAI_AUDIT_MDATA_CHECK_EN, silently overwrite those bits per REQ-015, tie audit_err to 0 and never drop for this cause.

Verification
REQ-028 SHALL cover translation: vmid=3, offset_array[3]=64'h1000, c0 read at address 42'h20 -> 2 cycles later out c0 valid, address 42'h1020, mdata[15:13]=3'd3.
REQ-029 SHALL cover wrap: offset 64'h1, address 42'h3FF_FFFF_FFFF -> output address 42'h0, no error.
REQ-030 SHALL cover gating: sub_afu_reset=64'h4, c0 and c1 requests in the same cycle on vmid 2 -> no output valids, drop_cnt 0 -> 2; vmid 1 request in the next cycle passes.
REQ-031 SHALL cover fence/c2: c1 WRFENCE on vmid 5 with offset 64'h80 plus c2 response on the same cycle -> both out after 2 cycles, fence address unchanged, c2 bit-identical.
REQ-032 SHALL cover config: with VAI_AUDIT_MDATA_CHECK_EN, c0 with mdata=16'hE000 -> dropped, audit_err=1, drop_cnt +1; without it, forwarded with mdata[15:13]=vmid, audit_err=0.
REQ-033 SHALL cover reset mid-flight: request issued, Resetb low 1 cycle later -> no valid output ever, drop_cnt=0 after release.
